pin_collector: RTL and testbench
================================

# pin_collector

Upstream input stage for the one-hot control FSM. It collects a fixed number of BCD digits, strobed one at a time from the keypad/decoder, into one packed code word. It then presents the complete code with a one-cycle `code_valid` pulse. Malformed digits and inter-digit timeouts produce a one-cycle `error` pulse, so the downstream controller only ever sees complete, legal codes.

## Interface
- `DIGITS`, default 4: number of BCD digits per code, must be ≥ 1.
- `TIMEOUT`, default 16: maximum consecutive idle cycles allowed between digits, must be ≥ 1.
- `clk`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `digit_valid`, input, 1: `digit` is presented this cycle.
- `digit`, input, 4: BCD digit; values above 9 are illegal.
- `clear`, input, 1: synchronous abort of the current entry.
- `code`, output, 4*DIGITS: packed code; first digit in the MS nibble, last digit in the LS nibble.
- `code_valid`, output, 1: one-cycle pulse; `code` is complete.
- `error`, output, 1: one-cycle pulse; the entry was aborted because of an illegal digit or a timeout.
- `busy`, output, 1: an entry is in progress (state COLLECT).

## Operation
- The FSM is one-hot with 4 states: IDLE, COLLECT, DONE, ERROR.
- Reset (`reset`=0 at an edge):
  - state = IDLE; `code` = 0; digit counter = 0; timer = 0.
  - Outputs: `code_valid`=0, `error`=0, `busy`=0.
- Priority at each edge: reset > clear > `digit_valid` > timeout.
- `clear`=1 (from any state):
  - Next state is IDLE; `code`, counter and timer are zeroed.
  - No `code_valid` or `error` pulse is produced.
- IDLE:
  - `digit_valid`=1 with `digit` ≤ 9: `code` ← zero-extended `digit`, counter ← 1, timer ← 0. Next state is DONE if DIGITS=1, otherwise COLLECT.
  - `digit_valid`=1 with `digit` > 9: next state ERROR.
  - Otherwise stay in IDLE; `code` holds its last value.
- COLLECT:
  - Legal digit: `code` ← {`code`[4*DIGITS-5:0], `digit`}, counter +1, timer ← 0. When the new count equals DIGITS, go to DONE; otherwise stay in COLLECT.
  - Illegal digit (> 9): go to ERROR.
  - No digit: timer +1. If the timer was already TIMEOUT-1, go to ERROR instead.
- DONE:
  - `code_valid`=1 and `code` is stable.
  - `digit_valid` is ignored; the digit is dropped.
  - Next state is IDLE unconditionally (unless `clear` or reset applies).
- ERROR:
  - `error`=1; `code` is zeroed on entry; counter and timer are zeroed.
  - `digit_valid` is ignored.
  - Next state is IDLE.
- All outputs are registered/Moore: `code_valid` = (state==DONE), `error` = (state==ERROR), `busy` = (state==COLLECT).
- Widths:
  - Counter is $clog2(DIGITS+1) bits; timer is $clog2(TIMEOUT+1) bits. Neither ever wraps.
  - The `code` shift discards nothing, because at most DIGITS nibbles are ever shifted in.

## Timing
- Latency: the edge that accepts the last digit moves the FSM to DONE, and `code_valid` is high for exactly the following cycle.
- `digit_valid` is sampled each edge; one digit is accepted per cycle, and back-to-back digits are allowed.
- Timeout window: after the edge that accepts digit n (n < DIGITS), TIMEOUT consecutive edges with `digit_valid`=0 move the FSM to ERROR on the TIMEOUT-th edge.
  - A legal digit arriving on the TIMEOUT-th edge is accepted.
- `error` is high for exactly 1 cycle, the cycle after the detecting edge.
- Minimum spacing between two codes is DIGITS+1 cycles; a digit presented during DONE is lost.
- A reset asserted mid-entry takes effect at that edge; no pulse is produced.

## Test plan
- Digits 1,2,3,4 on 4 consecutive edges (DIGITS=4) → `busy` high for cycles 2–4; `code`=16'h1234 with `code_valid`=1 for exactly the cycle after the 4th edge; then IDLE.
- Digits 9,8, then 16 idle cycles (TIMEOUT=16) → `error` pulse on the cycle after the 16th idle edge; `code`=0; `busy`=0.
- Digits 5,6, then 15 idle cycles, then 7,0 → no error; `code`=16'h5670 with a `code_valid` pulse.
- Digit 4'hA in IDLE, and separately 3 followed by 4'hF → an `error` pulse in each case; `code`=0.
- Digits 1,2, then `clear`=1 together with `digit_valid`=1 (digit 3) → IDLE, `code`=0, no pulse; a subsequent 4,3,2,1 gives 16'h4321.
- Digits 1,2,3, then `reset`=0 for 1 cycle → all outputs 0; 4th digit 4 → `code`=16'h0004, `busy`=1, no `code_valid`. Separately, a digit presented during DONE is ignored.

Source files
------------

// File: rtl/pin_collector.sv
// Collects DIGITS BCD digits into one packed code word and pulses code_valid when complete.
// An illegal digit or an inter-digit timeout aborts the entry with a one-cycle error pulse.
module pin_collector #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   code,
    output logic                  code_valid,
    output logic                  error,
    output logic                  busy
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        COLLECT = 4'b0010,
        DONE    = 4'b0100,
        ERROR   = 4'b1000
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [TW-1:0]  tmr;
    logic           legal;
    logic [W-1:0]   code_sh;

    assign legal   = (digit <= 4'd9);
    // Shift the new digit in at the LS nibble; the oldest digit ends up in the MS nibble.
    assign code_sh = (code << 4) | W'(digit);

    // Outputs are registered alongside the state so they track it exactly (Moore).
    always_ff @(posedge clk) begin
        code_valid <= 1'b0;
        error      <= 1'b0;
        busy       <= 1'b0;
        if (!reset || clear) begin
            state <= IDLE;
            code  <= '0;
            cnt   <= '0;
            tmr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (digit_valid) begin
                        if (legal) begin
                            code <= W'(digit);
                            cnt  <= CW'(1);
                            tmr  <= '0;
                            if (DIGITS == 1) begin
                                state      <= DONE;
                                code_valid <= 1'b1;
                            end else begin
                                state <= COLLECT;
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                            code  <= '0;
                            cnt   <= '0;
                            tmr   <= '0;
                        end
                    end
                end
                COLLECT: begin
                    if (digit_valid && legal) begin
                        code <= code_sh;
                        cnt  <= cnt + CW'(1);
                        tmr  <= '0;
                        if (cnt == CNT_LAST) begin
                            state      <= DONE;
                            code_valid <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                        end
                    end else if (digit_valid || tmr == TMR_LAST) begin
                        state <= ERROR;
                        error <= 1'b1;
                        code  <= '0;
                        cnt   <= '0;
                        tmr   <= '0;
                    end else begin
                        tmr  <= tmr + TW'(1);
                        busy <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tmr   <= '0;
                end
                ERROR: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tmr   <= '0;
                end
                default: begin
                    state <= IDLE;
                    code  <= '0;
                    cnt   <= '0;
                    tmr   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pin_collector.sv
// Directed bench for pin_collector (DIGITS=4, TIMEOUT=16) with hand-computed expectations.
module tb_pin_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        clear;
    logic [15:0] code;
    logic        code_valid;
    logic        error;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    pin_collector #(.DIGITS(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .clear(clear), .code(code), .code_valid(code_valid), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply the current inputs at one rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic idle(input int n);
        digit_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic outs(input string tag, input logic [15:0] c, input logic cv,
                        input logic er, input logic bz);
        chk({tag, ".code"}, 32'(code), 32'(c));
        chk({tag, ".cv"},   32'(code_valid), 32'(cv));
        chk({tag, ".err"},  32'(error), 32'(er));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    initial begin
        reset = 1'b0; digit_valid = 1'b0; digit = 4'd0; clear = 1'b0;
        step(); step();
        outs("reset", 16'h0, 0, 0, 0);
        reset = 1'b1;

        // Four back-to-back digits
        key(4'd1); outs("d1", 16'h0001, 0, 0, 1);
        key(4'd2); outs("d2", 16'h0012, 0, 0, 1);
        key(4'd3); outs("d3", 16'h0123, 0, 0, 1);
        key(4'd4); outs("d4", 16'h1234, 1, 0, 0);
        idle(1);   outs("post", 16'h1234, 0, 0, 0);

        // Timeout after two digits
        key(4'd9); key(4'd8);
        idle(15);  outs("to15", 16'h0098, 0, 0, 1);
        idle(1);   outs("to16", 16'h0, 0, 1, 0);
        idle(1);   outs("toend", 16'h0, 0, 0, 0);

        // Digit on the last allowed edge is accepted
        key(4'd5); key(4'd6);
        idle(15);  outs("edge15", 16'h0056, 0, 0, 1);
        key(4'd7); outs("edge16", 16'h0567, 0, 0, 1);
        key(4'd0); outs("edgeok", 16'h5670, 1, 0, 0);
        idle(1);

        // Illegal digits
        key(4'hA); outs("illidle", 16'h0, 0, 1, 0);
        idle(1);   outs("illend", 16'h0, 0, 0, 0);
        key(4'd3); outs("ill3", 16'h0003, 0, 0, 1);
        key(4'hF); outs("illF", 16'h0, 0, 1, 0);
        idle(1);

        // Clear beats a simultaneous digit
        key(4'd1); key(4'd2);
        clear = 1'b1; key(4'd3); clear = 1'b0;
        outs("clr", 16'h0, 0, 0, 0);
        idle(1);   outs("clr2", 16'h0, 0, 0, 0);
        key(4'd4); key(4'd3); key(4'd2); key(4'd1);
        outs("aftclr", 16'h4321, 1, 0, 0);
        idle(1);

        // Reset mid-entry
        key(4'd1); key(4'd2); key(4'd3);
        reset = 1'b0; step(); reset = 1'b1;
        outs("midrst", 16'h0, 0, 0, 0);
        key(4'd4); outs("rst4", 16'h0004, 0, 0, 1);
        clear = 1'b1; step(); clear = 1'b0;

        // A digit presented during DONE is dropped
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        outs("done", 16'h1234, 1, 0, 0);
        key(4'd5); outs("drop", 16'h1234, 0, 0, 0);
        idle(1);   outs("drop2", 16'h1234, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
